// File: rtl/modexp_job_sequencer_if.sv
// Stream bundle between the ciphertext source, the sequencer and the result consumer.
// A word moves on any rising edge where valid && ready; the source holds valid and data stable until then.
interface modexp_job_sequencer_if #(
    parameter int MSGW = 12
);
    logic            in_valid;
    logic [MSGW-1:0] in_data;
    logic            in_ready;
    logic            out_valid;
    logic [MSGW-1:0] out_data;
    logic            out_err;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/modexp_job_sequencer.sv
// Feeds buffered ciphertext words one at a time into a modexp engine and returns
// each result, with zero-modulus and hung-job protection.
module modexp_job_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096,
    parameter int MSGW       = 12,
    parameter int KEYW       = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    modexp_job_sequencer_if.slave        io,
    input  logic                         cfg_we,
    input  logic [KEYW-1:0]              cfg_key,
    input  logic [KEYW-1:0]              cfg_n,
    output logic                         cfg_ack,
    output logic [MSGW-1:0]              eng_msg,
    output logic [KEYW-1:0]              eng_key,
    output logic [KEYW-1:0]              eng_n,
    output logic                         eng_start,
    output logic                         eng_rst,
    input  logic                         eng_done,
    input  logic [MSGW-1:0]              eng_out,
    output logic                         busy,
    output logic [15:0]                  jobs_done,
    output logic [2:0]                   dbg_state
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ERRN, CLEAR, LAUNCH, WAIT} state_t;

    state_t          state, state_nx;
    logic [MSGW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   tmo_cnt;
    logic [KEYW-1:0] key_q, n_q;
    logic            out_valid_q, out_err_q;
    logic [MSGW-1:0] out_data_q;
    logic            fifo_empty, push, pop, cfg_ok, timed_out;

    assign fifo_empty  = (count == '0);
    assign io.in_ready = (count != FULL_CNT);
    assign push        = io.in_valid && io.in_ready;
    // A pending result blocks the next launch, so a transfer cycle never pops.
    assign pop         = (state == IDLE) && !fifo_empty && !out_valid_q;
    assign cfg_ok      = cfg_we && (state == IDLE) && fifo_empty;
    assign timed_out   = (tmo_cnt == TMO_LAST);

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_err   = out_err_q;
    assign eng_key      = key_q;
    assign eng_n        = n_q;
    assign busy         = (state != IDLE) || !fifo_empty || out_valid_q;
    assign dbg_state    = state;

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        eng_rst   = 1'b1;
        case (state)
            IDLE:   if (pop) state_nx = (n_q == '0) ? ERRN : CLEAR;
            ERRN:   state_nx = IDLE;
            CLEAR:  state_nx = LAUNCH;
            LAUNCH: begin
                eng_start = 1'b1;
                eng_rst   = 1'b0;
                state_nx  = WAIT;
            end
            WAIT: begin
                eng_start = 1'b1;
                eng_rst   = 1'b0;
                if (eng_done || timed_out) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            key_q       <= '0;
            n_q         <= '0;
            cfg_ack     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            eng_msg     <= '0;
            jobs_done   <= '0;
            tmo_cnt     <= '0;
        end else begin
            state   <= state_nx;
            cfg_ack <= cfg_ok;
            if (cfg_ok) begin
                key_q <= cfg_key;
                n_q   <= cfg_n;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                eng_msg <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count <= count + CNTW'(push) - CNTW'(pop);

            if (state == LAUNCH)    tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;

            if (io.out_valid && io.out_ready) out_valid_q <= 1'b0;

            // eng_done is checked first so a finish on the last allowed cycle still counts as good.
            if (state == ERRN || (state == WAIT && !eng_done && timed_out)) begin
                out_valid_q <= 1'b1;
                out_data_q  <= '0;
                out_err_q   <= 1'b1;
                jobs_done   <= jobs_done + 1'b1;
            end else if (state == WAIT && eng_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= eng_out;
                out_err_q   <= 1'b0;
                jobs_done   <= jobs_done + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_modexp_job_sequencer.sv
// Randomised and directed bench for modexp_job_sequencer with a behavioural engine
// model and a result scoreboard built from plain modular arithmetic.
module tb_modexp_job_sequencer;
    localparam int MSGW    = 12;
    localparam int KEYW    = 24;
    localparam int TIMEOUT = 32;
    localparam int DEPTH   = 4;

    logic            clk;
    logic            rst;
    logic            cfg_we;
    logic [KEYW-1:0] cfg_key, cfg_n;
    logic            cfg_ack;
    logic [MSGW-1:0] eng_msg;
    logic [KEYW-1:0] eng_key, eng_n;
    logic            eng_start, eng_rst, eng_done;
    logic [MSGW-1:0] eng_out;
    logic            busy;
    logic [15:0]     jobs_done;
    logic [2:0]      dbg_state;

    modexp_job_sequencer_if #(.MSGW(MSGW)) io ();

    modexp_job_sequencer #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MSGW(MSGW), .KEYW(KEYW)
    ) dut (
        .clk(clk), .rst(rst), .io(io),
        .cfg_we(cfg_we), .cfg_key(cfg_key), .cfg_n(cfg_n), .cfg_ack(cfg_ack),
        .eng_msg(eng_msg), .eng_key(eng_key), .eng_n(eng_n),
        .eng_start(eng_start), .eng_rst(eng_rst), .eng_done(eng_done), .eng_out(eng_out),
        .busy(busy), .jobs_done(jobs_done), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cnt = 0;
    int job_cnt  = 0;
    logic [KEYW-1:0] m_key = '0, m_n = '0;
    logic [MSGW:0] exp_q[$];
    int lat_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [MSGW-1:0] modpow(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r;
        if (m == 0) return '0;
        b = b % m;
        r = 1 % m;
        for (int i = KEYW - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r[MSGW-1:0];
    endfunction

    // Engine model: finishes after the per-job latency counted in started cycles.
    int   eng_cnt = 0;
    int   eng_lat = 1;
    logic eng_loaded = 1'b0;
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_cnt    <= 0;
            eng_loaded <= 1'b0;
        end else if (eng_start) begin
            if (!eng_loaded) begin
                eng_lat    <= (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                eng_loaded <= 1'b1;
            end
            eng_cnt <= eng_cnt + 1;
        end
    end
    assign eng_done = eng_loaded && (eng_cnt >= eng_lat);
    assign eng_out  = eng_done ? modpow(64'(eng_msg), 64'(eng_key), 64'(eng_n)) : '0;

    // scoreboard: every cycle a result is offered it must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && io.out_valid) begin
            if (exp_q.size() == 0) check_eq("result_expected", 32'(exp_q.size()), 32'd1);
            else begin
                check_eq("result", {io.out_err, io.out_data}, exp_q[0]);
                if (io.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [MSGW-1:0] w, input int lat, output int acc);
        int g;
        logic [MSGW:0] e;
        g = 0;
        io.in_valid = 1'b1;
        io.in_data  = w;
        @(negedge clk);
        while (!io.in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check_eq("push_timeout", 32'(g), 32'd0);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        acc = cyc;
        if (m_n == 0 || lat > TIMEOUT) e = {1'b1, {MSGW{1'b0}}};
        else e = {1'b0, modpow(64'(w), 64'(m_key), 64'(m_n))};
        exp_q.push_back(e);
        if (m_n != 0) lat_q.push_back(lat);
        job_cnt++;
    endtask

    task automatic wait_valid(output int at);
        int g;
        g = 0;
        @(negedge clk);
        while (!io.out_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check_eq("out_valid_timeout", 32'(g), 32'd0);
        at = cyc;
    endtask

    task automatic wait_start();
        int g;
        g = 0;
        @(negedge clk);
        while (!eng_start && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check_eq("eng_start_timeout", 32'(g), 32'd0);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        check_eq(tag, 32'(jobs_done), 32'(job_cnt[15:0]));
        sync();
    endtask

    task automatic do_cfg(input logic [KEYW-1:0] k, input logic [KEYW-1:0] nn);
        cfg_key = k;
        cfg_n   = nn;
        cfg_we  = 1'b1;
        sync();
        cfg_we  = 1'b0;
        @(negedge clk);
        check_eq("cfg_ack", 32'(cfg_ack), 32'd1);
        check_eq("cfg_key", 32'(eng_key), 32'(k));
        check_eq("cfg_n", 32'(eng_n), 32'(nn));
        m_key = k;
        m_n   = nn;
        sync();
        check_eq("cfg_ack_pulse", 32'(cfg_ack), 32'd0);
    endtask

    initial begin
        int acc, at, k;
        logic rnd_done;
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_key = '0;
        cfg_n = '0;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(io.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(io.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(io.out_data), 32'd0);
        check_eq("rst_out_err", 32'(io.out_err), 32'd0);
        check_eq("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        check_eq("rst_eng_start", 32'(eng_start), 32'd0);
        check_eq("rst_eng_rst", 32'(eng_rst), 32'd1);
        check_eq("rst_eng_msg", 32'(eng_msg), 32'd0);
        check_eq("rst_eng_key", 32'(eng_key), 32'd0);
        check_eq("rst_eng_n", 32'(eng_n), 32'd0);
        check_eq("rst_jobs_done", 32'(jobs_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        sync();

        // basic job: 2^7 mod 33, engine takes 20 cycles
        do_cfg(24'd7, 24'd33);
        push_word(12'd2, 20, acc);
        wait_valid(at);
        check_eq("basic_latency", 32'(at - acc), 32'd23);
        drain("basic_jobs");

        // back-to-back fill until the FIFO is full
        do_cfg(24'd3, 24'd33);
        push_word(12'd2, 20, acc);
        push_word(12'd4, 20, acc);
        push_word(12'd5, 20, acc);
        push_word(12'd6, 20, acc);
        push_word(12'd7, 20, acc);
        io.in_valid = 1'b1;
        io.in_data  = 12'd9;
        @(negedge clk);
        check_eq("full_in_ready", 32'(io.in_ready), 32'd0);
        sync();
        io.in_valid = 1'b0;
        drain("b2b_jobs");

        // backpressure holds the result and blocks the next launch
        io.out_ready = 1'b0;
        push_word(12'd2, 5, acc);
        push_word(12'd4, 5, acc);
        wait_valid(at);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_no_launch", 32'(eng_start), 32'd0);
            check_eq("bp_held_valid", 32'(io.out_valid), 32'd1);
        end
        sync();
        io.out_ready = 1'b1;
        sync();
        io.out_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!eng_start && k < 20);
        check_eq("bp_relaunch_delay", 32'(k), 32'd3);
        io.out_ready = 1'b1;
        drain("bp_jobs");

        // timeout boundary: never done, done on the last allowed cycle, then a normal job
        push_word(12'd5, 1000, acc);
        wait_valid(at);
        check_eq("tmo_latency", 32'(at - acc), 32'(TIMEOUT + 3));
        drain("tmo_jobs");
        push_word(12'd6, TIMEOUT, acc);
        wait_valid(at);
        check_eq("tmo_edge_latency", 32'(at - acc), 32'(TIMEOUT + 3));
        drain("tmo_edge_jobs");
        push_word(12'd4, 3, acc);
        wait_valid(at);
        check_eq("post_tmo_latency", 32'(at - acc), 32'd6);
        drain("post_tmo_jobs");

        // zero modulus never starts the engine
        do_cfg(24'd5, 24'd0);
        start_cnt = 0;
        push_word(12'd9, 1, acc);
        wait_valid(at);
        check_eq("errn_latency", 32'(at - acc), 32'd2);
        drain("errn_jobs");
        check_eq("errn_no_start", 32'(start_cnt), 32'd0);

        // config write while a job runs is ignored
        do_cfg(24'd3, 24'd33);
        push_word(12'd8, 20, acc);
        wait_start();
        sync();
        cfg_key = 24'd99;
        cfg_n   = 24'd77;
        cfg_we  = 1'b1;
        sync();
        cfg_we  = 1'b0;
        @(negedge clk);
        check_eq("guard_no_ack", 32'(cfg_ack), 32'd0);
        check_eq("guard_key", 32'(eng_key), 32'd3);
        check_eq("guard_n", 32'(eng_n), 32'd33);
        drain("guard_jobs");

        // randomized rounds with random backpressure and engine latencies
        for (int r = 0; r < 6; r++) begin
            logic [KEYW-1:0] rk, rn;
            rk = KEYW'($urandom_range(0, 24'hFFFFFF));
            rn = ($urandom_range(0, 5) == 0) ? '0 : KEYW'($urandom_range(1, 4095));
            do_cfg(rk, rn);
            rnd_done = 1'b0;
            fork
                begin
                    for (int j = 0; j < 12; j++) begin
                        int gap;
                        gap = $urandom_range(0, 3);
                        repeat (gap) sync();
                        push_word(MSGW'($urandom_range(0, 4095)), $urandom_range(1, TIMEOUT + 8), acc);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        sync();
                        io.out_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            io.out_ready = 1'b1;
            drain("rand_jobs");
        end

        // asynchronous reset in the middle of a job, with words still queued
        do_cfg(24'd3, 24'd33);
        push_word(12'd5, 20, acc);
        push_word(12'd6, 20, acc);
        push_word(12'd7, 20, acc);
        wait_start();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_eng_start", 32'(eng_start), 32'd0);
        check_eq("arst_eng_rst", 32'(eng_rst), 32'd1);
        check_eq("arst_out_valid", 32'(io.out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(io.in_ready), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_jobs_done", 32'(jobs_done), 32'd0);
        exp_q.delete();
        lat_q.delete();
        job_cnt = 0;
        m_key = '0;
        m_n = '0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("arst_eng_n", 32'(eng_n), 32'd0);
        sync();
        do_cfg(24'd7, 24'd33);
        push_word(12'd2, 4, acc);
        wait_valid(at);
        check_eq("post_rst_latency", 32'(at - acc), 32'd7);
        drain("post_rst_jobs");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
